// File: rtl/regfile_hilo.sv
// 31x32 GPR file with HI/LO pair and a committed-write counter.
// Optional same-cycle write-to-read bypass: define RF_WB_BYPASS_EN.
module regfile_hilo #(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_to_rf_bus,
    input  logic [65:0] hilo_wb_to_rf_bus,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic [15:0] wr_count
);

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic        lo_we;
    logic        gpr_we;

    logic [31:0] gpr [1:31];
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] cnt;

    logic [31:0] stored1;
    logic [31:0] stored2;

    assign we       = wb_to_rf_bus[37];
    assign waddr    = wb_to_rf_bus[36:32];
    assign wdata    = wb_to_rf_bus[31:0];
    assign hi_wdata = hilo_wb_to_rf_bus[65:34];
    assign lo_wdata = hilo_wb_to_rf_bus[33:2];
    assign hi_we    = hilo_wb_to_rf_bus[1];
    assign lo_we    = hilo_wb_to_rf_bus[0];

    // $0 is hardwired, so writes to it never commit or count
    assign gpr_we = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                gpr[i] <= RST_VAL;
            end
            hi  <= RST_VAL;
            lo  <= RST_VAL;
            cnt <= 16'h0;
        end else begin
            if (gpr_we) begin
                gpr[waddr] <= wdata;
                cnt        <= cnt + 16'h1;
            end
            if (hi_we) begin
                hi <= hi_wdata;
            end
            if (lo_we) begin
                lo <= lo_wdata;
            end
        end
    end

    assign stored1  = (raddr1 == 5'd0) ? 32'h0 : gpr[raddr1];
    assign stored2  = (raddr2 == 5'd0) ? 32'h0 : gpr[raddr2];
    assign wr_count = cnt;

`ifdef RF_WB_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1     = !rst && gpr_we && (raddr1 == waddr);
    assign byp2     = !rst && gpr_we && (raddr2 == waddr);
    assign rdata1   = byp1 ? wdata : stored1;
    assign rdata2   = byp2 ? wdata : stored2;
    assign hi_rdata = (!rst && hi_we) ? hi_wdata : hi;
    assign lo_rdata = (!rst && lo_we) ? lo_wdata : lo;
`else
    assign rdata1   = stored1;
    assign rdata2   = stored2;
    assign hi_rdata = hi;
    assign lo_rdata = lo;
`endif

endmodule

// File: tb/tb_regfile_hilo.sv
// Bench for regfile_hilo: reference model plus directed vectors.
// Expectations follow RF_WB_BYPASS_EN when it is defined.
module tb_regfile_hilo;

    localparam logic [31:0] RV = 32'hA5A5_0001;

    logic        clk;
    logic        rst;
    logic [37:0] wb_to_rf_bus;
    logic [65:0] hilo_wb_to_rf_bus;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk   = 0;

    logic [31:0] m_gpr [0:31];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_cnt;

    regfile_hilo #(.RST_VAL(RV)) dut (
        .clk               (clk),
        .rst               (rst),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .hilo_wb_to_rf_bus (hilo_wb_to_rf_bus),
        .raddr1            (raddr1),
        .raddr2            (raddr2),
        .rdata1            (rdata1),
        .rdata2            (rdata2),
        .hi_rdata          (hi_rdata),
        .lo_rdata          (lo_rdata),
        .wr_count          (wr_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    bit bypass;
    initial begin
`ifdef RF_WB_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bypass && !rst && wb_to_rf_bus[37] &&
            wb_to_rf_bus[36:32] != 0 && wb_to_rf_bus[36:32] == a)
            return wb_to_rf_bus[31:0];
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (bypass && !rst && hilo_wb_to_rf_bus[1])
            return hilo_wb_to_rf_bus[65:34];
        return m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (bypass && !rst && hilo_wb_to_rf_bus[0])
            return hilo_wb_to_rf_bus[33:2];
        return m_lo;
    endfunction

    // Reference state: what the architectural registers hold after each edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) m_gpr[i] <= RV;
            m_hi  <= RV;
            m_lo  <= RV;
            m_cnt <= 0;
        end else begin
            if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] != 0) begin
                m_gpr[wb_to_rf_bus[36:32]] <= wb_to_rf_bus[31:0];
                m_cnt <= (m_cnt + 1) % 65536;
            end
            if (hilo_wb_to_rf_bus[1]) m_hi <= hilo_wb_to_rf_bus[65:34];
            if (hilo_wb_to_rf_bus[0]) m_lo <= hilo_wb_to_rf_bus[33:2];
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            cmp("model_rdata1", rdata1, exp_rd(raddr1));
            cmp("model_rdata2", rdata2, exp_rd(raddr2));
            cmp("model_hi", hi_rdata, exp_hi());
            cmp("model_lo", lo_rdata, exp_lo());
            cmp("model_wr_count", {16'h0, wr_count}, m_cnt[31:0]);
        end
    end

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [65:0] h);
        @(posedge clk);
        #1;
        rst               = r;
        wb_to_rf_bus      = {w, a, d};
        hilo_wb_to_rf_bus = h;
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 32'h0, 66'h0);
    endtask

    initial begin
        rst               = 1;
        wb_to_rf_bus      = '0;
        hilo_wb_to_rf_bus = '0;
        raddr1            = 0;
        raddr2            = 0;

        drive(1, 1, 5'd3, 32'h1111_1111, {32'h1, 32'h2, 2'b11});
        idle();
        chk = 1;

        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            @(negedge clk);
            cmp("reset_read", rdata1, (i == 0) ? 32'h0 : RV);
            idle();
        end
        @(negedge clk);
        cmp("reset_hi", hi_rdata, RV);
        cmp("reset_lo", lo_rdata, RV);
        cmp("reset_count", {16'h0, wr_count}, 32'h0);

        drive(0, 1, 5'd5, 32'hDEAD_BEEF, 66'h0);
        raddr1 = 5;
        raddr2 = 0;
        @(negedge clk);
        cmp("same_cycle_r5", rdata1, bypass ? 32'hDEAD_BEEF : RV);
        idle();
        @(negedge clk);
        cmp("next_cycle_r5", rdata1, 32'hDEAD_BEEF);
        cmp("count_one", {16'h0, wr_count}, 32'h1);

        drive(0, 1, 5'd0, 32'hFFFF_FFFF, 66'h0);
        raddr1 = 0;
        @(negedge clk);
        cmp("r0_same", rdata1, 32'h0);
        idle();
        @(negedge clk);
        cmp("r0_next", rdata1, 32'h0);
        cmp("count_r0", {16'h0, wr_count}, 32'h1);

        drive(0, 0, 5'd0, 32'h0, {32'h1234_5678, 32'h9ABC_DEF0, 2'b10});
        idle();
        @(negedge clk);
        cmp("hi_write", hi_rdata, 32'h1234_5678);
        cmp("lo_kept", lo_rdata, RV);

        drive(0, 1, 5'd9, 32'h0000_0055, {32'hCAFE_0001, 32'hBEEF_0002, 2'b11});
        raddr1 = 9;
        raddr2 = 9;
        idle();
        @(negedge clk);
        cmp("dual_r9", rdata2, 32'h0000_0055);
        cmp("dual_hi", hi_rdata, 32'hCAFE_0001);
        cmp("dual_lo", lo_rdata, 32'hBEEF_0002);
        cmp("count_two", {16'h0, wr_count}, 32'h2);

        drive(0, 1, 5'd7, 32'h0000_0077, 66'h0);
        raddr1 = 7;
        drive(1, 1, 5'd7, 32'h0000_0001, {32'h5, 32'h6, 2'b11});
        @(negedge clk);
        cmp("rst_no_bypass", rdata1, 32'h0000_0077);
        cmp("rst_no_hi_byp", hi_rdata, 32'hCAFE_0001);
        idle();
        @(negedge clk);
        cmp("rst_r7", rdata1, RV);
        cmp("rst_hi", hi_rdata, RV);
        cmp("rst_count", {16'h0, wr_count}, 32'h0);

        raddr1 = 1;
        raddr2 = 31;
        for (int i = 0; i < 65536; i++) begin
            drive(0, 1, 5'((i % 31) + 1), 32'(i), 66'h0);
            if (i == 65535) begin
                @(negedge clk);
                cmp("count_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
            end
        end
        idle();
        @(negedge clk);
        cmp("count_wrap", {16'h0, wr_count}, 32'h0);

        idle();
        @(negedge clk);
        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 SHALL have parameter RST_VAL, default 32'h0: value loaded into GPR[1..31], HI and LO on reset.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port wb_to_rf_bus, input, 38 (`WB_TO_RF_WD): {we[37], waddr[36:32], wdata[31:0]} from write-back stage.
REQ-006 Port hilo_wb_to_rf_bus, input, 66: {hi_wdata[65:34], lo_wdata[33:2], hi_we[1], lo_we[0]} from write-back stage.
REQ-007 Port raddr1, input, 5: read port 1 address.
REQ-008 Port raddr2, input, 5: read port 2 address.
REQ-009 Port rdata1, output, 32: read port 1 data.
REQ-010 Port rdata2, output, 32: read port 2 data.
REQ-011 Port hi_rdata, output, 32: HI read data.
REQ-012 Port lo_rdata, output, 32: LO read data.
REQ-013 Port wr_count, output, 16: number of committed GPR writes since reset, excluding writes to $0.

Function
REQ-014 SHALL hold 31 32-bit GPRs (1..31), one 32-bit HI and one 32-bit LO, all flops.
REQ-015 On a rising edge with we=1 and waddr!=0, GPR[waddr] SHALL take wdata; the new value is visible from the next cycle.
REQ-016 Writes with waddr=0 SHALL be discarded; reads of address 0 SHALL return 32'h0 in every case.
REQ-017 On a rising edge with hi_we=1, HI SHALL take hi_wdata; with lo_we=1, LO SHALL take lo_wdata; the two enables are independent.
REQ-018 Read ports SHALL be combinational and zero latency; both ports MAY address the same register.
REQ-019 wr_count SHALL increment by 1 on each edge that commits a GPR write (REQ-015); it wraps from 16'hFFFF to 16'h0000.
REQ-020 GPR and HI/LO writes in the same cycle SHALL both commit.
REQ-021 An all-zero write-back bus (pipeline bubble) SHALL change no state and no counter.

Reset
REQ-022 While rst=1 at a rising edge, GPR[1..31], HI and LO SHALL load RST_VAL, and wr_count SHALL load 0; write-back inputs in that cycle SHALL be ignored.
REQ-023 Reset asserted mid-stream SHALL take priority over any simultaneous write.
REQ-024 Outputs after reset: rdata1/rdata2 = RST_VAL for nonzero addresses and 0 for $0; hi_rdata = lo_rdata = RST_VAL; wr_count = 0.

Configuration
REQ-025 Macro RF_WB_BYPASS_EN SHALL select write-to-read bypass.
REQ-026 With RF_WB_BYPASS_EN defined: if we=1, waddr!=0 and raddrN=waddr, rdataN SHALL return wdata in the same cycle; if hi_we=1, hi_rdata SHALL return hi_wdata; if lo_we=1, lo_rdata SHALL return lo_wdata. Bypass SHALL be suppressed while rst=1.
REQ-027 Without RF_WB_BYPASS_EN: all reads SHALL return stored values only; same-cycle writes become visible the following cycle.

Verification
REQ-028 Reset, then read all 32 addresses -> $0 = 0, others = RST_VAL, hi/lo = RST_VAL, wr_count = 0.
REQ-029 Write we=1, waddr=5, wdata=32'hDEADBEEF; read raddr1=5 in the same cycle -> 32'hDEADBEEF with the bypass macro, old value without it; next cycle -> 32'hDEADBEEF in both builds; wr_count = 1.
REQ-030 Write waddr=0, wdata=32'hFFFFFFFF -> raddr1=0 reads 0 in both builds; wr_count unchanged.
REQ-031 hilo bus {32'h1234_5678, 32'h9ABC_DEF0, 1, 0} -> next cycle HI = 32'h12345678, LO unchanged.
REQ-032 Assert rst in the same cycle as a write (waddr=7, wdata=32'h1) -> GPR7 = RST_VAL, wr_count = 0, no bypass output.
REQ-033 65536 consecutive valid writes from reset -> wr_count wraps to 0.
